daq_buffer_reader: RTL and testbench
====================================

# daq_buffer_reader

Single-clock drain engine for the DAQ event buffer. Walks the 32k x 32 buffer from its read pointer up to the writer's committed pointer, parses a length header at the start of each event, and streams header plus payload onto a ready/valid output with an end-of-event marker. Returns the freed read pointer to the writer side so buffer space can be reused.

## Interface
Parameters:
- MAX_LEN, 16'd4096, largest legal payload word count per event (used only when the length check is compiled in)

Ports:
- clk  in  1  system clock; buffer read port runs on this clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start new events while high
- wr_commit  in  15  writer's committed pointer: one past the last word of the last complete event
- addrb  out  15  buffer read address
- doutb  in  32  buffer read data, valid on the cycle after the address cycle (registered read)
- m_data  out  32  output word
- m_valid  out  1  output word valid
- m_last  out  1  final word of the event
- m_ready  in  1  downstream accept
- rd_ptr  out  15  one past the last word of the last fully delivered event
- busy  out  1  event in progress
- occupancy  out  15  wr_commit - rd_ptr, modulo 2^15
- err_len  out  1  sticky length error (see Configuration)

## Operation
- Event format: word 0 = header, header[15:0] = N payload words; event spans N+1 words. N = 0 is legal (header-only event).
- States: IDLE, HDR, STREAM, DONE.
- IDLE: if enable and rd_ptr != wr_commit, issue read of header at rd_ptr, load internal fetch pointer, go HDR.
- HDR: capture header from doutb; remaining = N; push header into output queue; m_last on header iff N = 0. N = 0 -> DONE, else STREAM.
- STREAM: issue reads at fetch pointer + 1, ... while the output queue has credit; decrement remaining per issue; after final issue wait for data, then DONE. Final payload word carries m_last.
- DONE: once the m_last word is accepted (m_valid & m_ready), rd_ptr <= rd_ptr + N + 1 (15-bit wrap), go IDLE.
- Output queue: 2 entries; a read is issued only when queued + in-flight words < 2, or < 3 if a pop happens the same cycle. Continuous m_ready gives one word per cycle after the header.
- Addresses wrap from 0x7FFF to 0x0000 without a gap.
- enable deasserted mid-event: current event completes; no new event starts.
- m_data/m_last stay stable while m_valid & !m_ready.
- busy = state != IDLE or queue non-empty.

## Timing
- Reset values: addrb 0, m_data 0, m_valid 0, m_last 0, rd_ptr 0, busy 0, err_len 0, occupancy 0 (wr_commit held 0), state IDLE.
- Reset mid-event: everything returns to reset values immediately; the partial event is discarded. rd_ptr 0 must match a writer reset.
- Latency: wr_commit change visible in IDLE -> header on m_data 3 cycles later (address cycle, data cycle, queue register).
- rd_ptr updates the cycle after the final handshake; occupancy is combinational from rd_ptr and wr_commit.
- wr_commit advancing during an event has no effect until IDLE.

## Configuration
- DAQ_BUFFER_READER_LEN_CHECK_EN defined: a header with N > MAX_LEN is emitted alone with m_last = 1, err_len sets (sticky until reset), rd_ptr advances by 1 only.
- Not defined: no check; any N in 0..65535 is streamed; err_len tied 0.

## Test plan
- Header N=3 at 0x0000, payload A,B,C, wr_commit=4, m_ready=1 -> 4 words on consecutive cycles, m_last on C, rd_ptr=4, occupancy=0.
- Header N=0 at 0x0010, wr_commit=0x11 -> single word, m_last=1, rd_ptr=0x11.
- Event at 0x7FFE with N=3 -> reads 0x7FFE, 0x7FFF, 0x0000, 0x0001; rd_ptr=0x0002.
- N=5 with m_ready toggling 1/0 each cycle -> 6 words in order, none dropped or duplicated, data stable while stalled.
- Reset asserted during STREAM of N=10 -> m_valid=0 and rd_ptr=0 same cycle; after release with wr_commit=0, stays IDLE.
- With LEN_CHECK_EN and MAX_LEN=16, header N=100 -> header alone with m_last=1, err_len=1, rd_ptr+1; without macro, 101 words streamed, err_len=0.

Source files
------------

// File: rtl/daq_buffer_reader.sv
// Drain engine for the 32k x 32 DAQ event buffer: header parse, payload stream.
// Optional header length check: define DAQ_BUFFER_READER_LEN_CHECK_EN.
module daq_buffer_reader #(
   parameter logic [15:0] MAX_LEN = 16'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [14:0] wr_commit,
   output logic [14:0] addrb,
   input  logic [31:0] doutb,
   output logic [31:0] m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [14:0] rd_ptr,
   output logic        busy,
   output logic [14:0] occupancy,
   output logic        err_len
);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      STREAM,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [14:0] nxt;
   logic [15:0] rem;
   logic [14:0] adv;
   logic        pend;
   logic        pend_last;
   logic [1:0]  cnt;
   logic [31:0] d1;
   logic        l0;
   logic        l1;

   logic [15:0] n_hdr;
   logic        len_over;
   logic        bad;
   logic        pop;
   logic        push;
   logic        push_l;
   logic        issue;
   logic        pl_issue;
   logic        iss_last;
   logic        hdr_load;
   logic        done;
   logic [2:0]  inq;
   logic        credit;

   assign n_hdr    = doutb[15:0];
   assign len_over = n_hdr > MAX_LEN;

`ifdef DAQ_BUFFER_READER_LEN_CHECK_EN
   assign bad = len_over;
`else
   assign bad = len_over & 1'b0;
`endif

   assign m_valid   = cnt != 2'd0;
   assign m_last    = l0 & m_valid;
   assign pop       = m_valid & m_ready;
   assign busy      = (state != IDLE) | m_valid;
   assign occupancy = wr_commit - rd_ptr;

   // Words already queued plus the one landing on doutb this cycle.
   assign inq    = {1'b0, cnt} + {2'b00, pend};
   assign credit = pop ? (inq < 3'd3) : (inq < 3'd2);

   assign pl_issue = issue & (state != IDLE);

   always_comb begin
      state_n  = state;
      addrb    = nxt;
      issue    = 1'b0;
      iss_last = 1'b0;
      push     = pend;
      push_l   = pend_last;
      hdr_load = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            addrb = rd_ptr;
            if (enable && (rd_ptr != wr_commit)) begin
               issue   = 1'b1;
               state_n = HDR;
            end
         end
         HDR: begin
            push     = 1'b1;
            push_l   = (n_hdr == 16'd0) | bad;
            hdr_load = 1'b1;
            if (push_l) begin
               state_n = DONE;
            end else begin
               // First payload read overlaps the header cycle.
               issue    = 1'b1;
               iss_last = n_hdr == 16'd1;
               state_n  = STREAM;
            end
         end
         STREAM: begin
            if (rem == 16'd0) begin
               state_n = DONE;
            end else if (credit) begin
               issue    = 1'b1;
               iss_last = rem == 16'd1;
            end
         end
         DONE: begin
            if (pop && m_last) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rd_ptr    <= 15'd0;
         nxt       <= 15'd0;
         rem       <= 16'd0;
         adv       <= 15'd0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
      end else begin
         state <= state_n;
         pend  <= pl_issue;
         if (issue) begin
            nxt <= addrb + 15'd1;
         end
         if (pl_issue) begin
            pend_last <= iss_last;
         end
         if (hdr_load) begin
            rem <= pl_issue ? n_hdr - 16'd1 : n_hdr;
            adv <= bad ? 15'd1 : n_hdr[14:0] + 15'd1;
         end else if (pl_issue) begin
            rem <= rem - 16'd1;
         end
         if (done) begin
            rd_ptr <= rd_ptr + adv;
         end
      end
   end

   // Two-entry output queue; m_data is the head slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= 2'd0;
         m_data <= 32'd0;
         l0     <= 1'b0;
         d1     <= 32'd0;
         l1     <= 1'b0;
      end else begin
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            if (cnt == 2'd2) begin
               m_data <= d1;
               l0     <= l1;
               if (push) begin
                  d1 <= doutb;
                  l1 <= push_l;
               end
            end else if (push) begin
               m_data <= doutb;
               l0     <= push_l;
            end
         end else if (push) begin
            if (cnt == 2'd0) begin
               m_data <= doutb;
               l0     <= push_l;
            end else begin
               d1 <= doutb;
               l1 <= push_l;
            end
         end
      end
   end

`ifdef DAQ_BUFFER_READER_LEN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_len <= 1'b0;
      end else if (hdr_load && bad) begin
         err_len <= 1'b1;
      end
   end
`else
   assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_daq_buffer_reader.sv
// Bench for daq_buffer_reader: buffer memory model plus event-level reference.
module tb_daq_buffer_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [14:0] wr_commit;
   logic [14:0] addrb;
   logic [31:0] doutb;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic [14:0] rd_ptr;
   logic        busy;
   logic [14:0] occupancy;
   logic        err_len;

   logic [31:0] mem [0:32767];
   logic [32:0] expq [$];
   logic [14:0] rd_model;
   logic [14:0] e_end;
   logic [14:0] e2_end;
   int          tests = 0;
   int          fails = 0;
   int          fc;
   int          lc;

   always #5 clk = ~clk;

   always @(posedge clk) doutb <= mem[addrb];

   daq_buffer_reader #(.MAX_LEN(16'd16)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .wr_commit (wr_commit),
      .addrb     (addrb),
      .doutb     (doutb),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .rd_ptr    (rd_ptr),
      .busy      (busy),
      .occupancy (occupancy),
      .err_len   (err_len)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put_event(input logic [14:0] s, input int n,
                            output logic [14:0] e);
      logic [31:0] r;
      logic [14:0] a;
      r = $urandom();
      a = s;
      mem[a] = {r[31:16], n[15:0]};
      for (int i = 1; i <= n; i++) begin
         a = a + 15'd1;
         mem[a] = $urandom();
      end
      e = a + 15'd1;
   endtask

   // Expected stream of the event starting at rd_model.
   task automatic model_event();
      logic [31:0] h;
      logic [14:0] a;
      logic        bad;
      int          n;
      h = mem[rd_model];
      n = int'(h[15:0]);
`ifdef DAQ_BUFFER_READER_LEN_CHECK_EN
      bad = n > 16;
`else
      bad = 1'b0;
`endif
      expq.push_back({(n == 0) || bad, h});
      a = rd_model;
      if (!bad) begin
         for (int i = 1; i <= n; i++) begin
            a = a + 15'd1;
            expq.push_back({i == n, mem[a]});
         end
      end
      rd_model = bad ? rd_model + 15'd1 : rd_model + 15'(n + 1);
   endtask

   task automatic run_event(input int mode, input int budget,
                            output int first_c, output int last_c);
      int          cyc;
      logic        hv;
      logic [31:0] hd;
      logic        hl;
      logic [32:0] e;
      cyc = 0;
      hv = 1'b0;
      hd = '0;
      hl = 1'b0;
      first_c = -1;
      last_c = -1;
      while (expq.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (hv) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hd);
            chk("hold_last", m_last, hl);
         end
         case (mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc % 2) == 0;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (m_valid && m_ready) begin
            e = expq.pop_front();
            chk("data", m_data, e[31:0]);
            chk("last", m_last, e[32]);
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
         end
         hv = m_valid && !m_ready;
         hd = m_data;
         hl = m_last;
      end
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
   endtask

   task automatic post_check();
      @(negedge clk);
      chk("rd_ptr", rd_ptr, rd_model);
      chk("occupancy", occupancy, wr_commit - rd_model);
      chk("idle_valid", m_valid, 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic one_event(input int n, input int mode);
      put_event(rd_model, n, e_end);
      model_event();
      wr_commit = rd_model;
      run_event(mode, 4 * (n + 1) + 20, fc, lc);
      post_check();
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = $urandom();
      reset = 1'b1;
      enable = 1'b0;
      wr_commit = 15'd0;
      m_ready = 1'b0;
      rd_model = 15'd0;
      repeat (3) @(negedge clk);
      chk("rst_addrb", addrb, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_rd_ptr", rd_ptr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_occupancy", occupancy, 0);
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      chk("empty_busy", busy, 0);

      // N=3 at 0, continuous ready
      put_event(rd_model, 3, e_end);
      model_event();
      wr_commit = rd_model;
      run_event(0, 40, fc, lc);
      chk("hdr_latency", fc + 1, 3);
      chk("back_to_back", lc - fc, 3);
      post_check();

      // Fill up to 0x10, then a header-only event
      one_event(int'(15'h10 - rd_model) - 1, 2);
      one_event(0, 0);
      chk("hdr_only_rd", rd_ptr, 15'h11);

      // Long event up to 0x7FFE, then one wrapping the top
      one_event(int'(15'h7FFE - rd_model) - 1, 0);
      chk("pre_wrap_rd", rd_ptr, 15'h7FFE);
      one_event(3, 0);
      chk("wrap_rd", rd_ptr, 15'h0002);

      // Toggling ready
      one_event(5, 1);

      // Oversize header
      one_event(100, 2);
`ifdef DAQ_BUFFER_READER_LEN_CHECK_EN
      chk("err_len", err_len, 1);
`else
      chk("err_len", err_len, 0);
`endif

      for (int k = 0; k < 4; k++) one_event($urandom_range(0, 8), 2);

      // Enable dropped mid-event with a second event committed
      put_event(rd_model, 4, e_end);
      put_event(e_end, 2, e2_end);
      model_event();
      wr_commit = e2_end;
      m_ready = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      run_event(0, 40, fc, lc);
      post_check();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("disabled_busy", busy, 0);
      end
      chk("disabled_occ", occupancy, e2_end - e_end);
      enable = 1'b1;
      model_event();
      run_event(2, 40, fc, lc);
      post_check();

      // Reset during a long stream
      put_event(rd_model, 10, e_end);
      model_event();
      wr_commit = rd_model;
      m_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_reset_valid", m_valid, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_rd_ptr", rd_ptr, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_last", m_last, 0);
      chk("mid_rst_err", err_len, 0);
      chk("mid_rst_addrb", addrb, 0);
      expq.delete();
      wr_commit = 15'd0;
      rd_model = 15'd0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_valid", m_valid, 0);
      end
      chk("post_rst_rd_ptr", rd_ptr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
